// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller:
// the per-stage tracking slot, the bubble value and select encoding helpers.
package hazard_forward_unit_pkg;

    // Slots store rd at a fixed width; narrower register addresses are zero-extended.
    localparam int RD_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};

    localparam int SEL_REGFILE = 0;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Shift register of in-flight instruction slots: slot 0 is EX, slot k is EX+k.
// The caller decides whether a real entry or a bubble is inserted each clock.
module hazard_slot_pipe
    import hazard_forward_unit_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  slot_t                   entry,
    output slot_t [DEPTH-1:0]       slots
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= SLOT_BUBBLE;
            end
        end else begin
            slots[0] <= entry;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and registered EX operand forwarding selects for
// a pipeline with FWD_STAGES forwarding sources after EX.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int FWD_STAGES    = 2,
    parameter int LOAD_USE_DIST = 1,
    parameter int SEL_W         = sel_width(FWD_STAGES),
    parameter int CNT_W         = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  idex_bubble,
    output logic [SEL_W-1:0]      forward_a,
    output logic [SEL_W-1:0]      forward_b,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int DEPTH = FWD_STAGES + 1;

    slot_t [DEPTH-1:0] slots;
    slot_t             entry;
    logic              bubble_in;
    logic              load_hit;
    logic [SEL_W-1:0]  fwd_a_next;
    logic [SEL_W-1:0]  fwd_b_next;
    logic              slot_bits_unused;

    function automatic logic produces(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.reg_write && (r != '0) && (s.rd == RD_MAX_W'(r));
    endfunction

    // Only loads still inside the load-use window can stall the ID instruction.
    always_comb begin
        load_hit = 1'b0;
        for (int k = 0; k < LOAD_USE_DIST; k++) begin
            if (slots[k].mem_read &&
                (produces(slots[k], id_rs) || (id_uses_rt && produces(slots[k], id_rt)))) begin
                load_hit = 1'b1;
            end
        end
    end

    assign stall         = id_valid && !flush && load_hit;
    assign pc_write_en   = !stall;
    assign ifid_write_en = !stall;
    assign idex_bubble   = stall || flush;
    assign bubble_in     = stall || flush || !id_valid;

    always_comb begin
        entry = SLOT_BUBBLE;
        if (!bubble_in) begin
            entry = '{valid: 1'b1, rd: RD_MAX_W'(id_rd),
                      reg_write: id_reg_write, mem_read: id_mem_read};
        end
    end

    hazard_slot_pipe #(
        .DEPTH (DEPTH)
    ) u_slot_pipe (
        .clock (clock),
        .reset (reset),
        .entry (entry),
        .slots (slots)
    );

    // Scanning from the oldest source down lets the youngest producer win.
    always_comb begin
        fwd_a_next = SEL_W'(SEL_REGFILE);
        fwd_b_next = SEL_W'(SEL_REGFILE);
        for (int j = FWD_STAGES; j >= 1; j--) begin
            if (produces(slots[j-1], id_rs)) begin
                fwd_a_next = SEL_W'(j);
            end
            if (id_uses_rt && produces(slots[j-1], id_rt)) begin
                fwd_b_next = SEL_W'(j);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            forward_a <= SEL_W'(SEL_REGFILE);
            forward_b <= SEL_W'(SEL_REGFILE);
        end else if (bubble_in) begin
            forward_a <= SEL_W'(SEL_REGFILE);
            forward_b <= SEL_W'(SEL_REGFILE);
        end else begin
            forward_a <= fwd_a_next;
            forward_b <= fwd_b_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // The oldest slot and the high rd bits are tracked but never compared.
    assign slot_bits_unused = ^slots;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard-detection and forwarding controller for the pipelined MIPS core. It tracks the destination register of every in-flight instruction from EX onward. It produces registered forwarding selects for both EX-stage ALU operands, plus load-use stall and bubble controls. It replaces the fixed two-source forwarding block and generalises it to any number of forwarding stages and load-use distances, with flush support and a stall performance counter.

Parameters:
REG_ADDR_W, 5, register-file address width
FWD_STAGES, 2, forwarding sources after EX (1 = EX/MEM, 2 = MEM/WB, ...); range 1..7
LOAD_USE_DIST, 1, cycles a load result is unavailable for forwarding; range 1..FWD_STAGES
SEL_W, clog2(FWD_STAGES+1), forwarding select width (derived)
CNT_W, 16, stall counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_ADDR_W  ID source register A
id_rt  in  REG_ADDR_W  ID source register B
id_uses_rt  in  1  rt is a read operand (R-type, sw, beq)
id_rd  in  REG_ADDR_W  destination after regDest mux
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
flush  in  1  branch taken in EX; squash the ID instruction
stall  out  1  combinational load-use stall
pc_write_en  out  1  equals ~stall
ifid_write_en  out  1  equals ~stall
idex_bubble  out  1  combinational; stall or flush
forward_a  out  SEL_W  registered EX operand A select
forward_b  out  SEL_W  registered EX operand B select
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (asynchronous, active-high): all tracking slots invalid; forward_a, forward_b and stall_count go to 0. stall=0, pc_write_en=1, idex_bubble=0 while reset is held.
- Tracking: slots s[0..FWD_STAGES], each holding {valid, rd, reg_write, mem_read}. s[0] is the instruction in EX and s[k] is the instruction in stage EX+k.
- Slot update on each clock: s[k] <= s[k-1] for k >= 1. s[0] <= the ID entry when id_valid && !stall && !flush; otherwise s[0] <= bubble (valid=0).
- Producer: slot k matches register r when valid && reg_write && rd == r && r != 0. Register 0 never matches.
- Stall: asserted when id_valid, no flush, and some k in 0..LOAD_USE_DIST-1 has s[k].mem_read and matches id_rs, or matches id_rt with id_uses_rt=1.
- Multi-cycle stall: a stall lasts until the load has advanced beyond slot LOAD_USE_DIST-1. That is LOAD_USE_DIST-k cycles for a load found in slot k.
- Forward select, computed each clock for the instruction entering EX, with slots s[0..FWD_STAGES-1] as the future sources 1..FWD_STAGES:
  - forward_a <= the smallest j in 1..FWD_STAGES whose source s[j-1] matches id_rs; 0 if none.
  - forward_b is the same against id_rt, gated by id_uses_rt.
  - The youngest producer wins.
  - When a bubble is inserted (stall, flush, or !id_valid), both selects load 0.
- Latency: forward selects are valid one cycle after ID presentation, aligned with the operands in EX. stall, pc_write_en, ifid_write_en and idex_bubble are same-cycle combinational.
- Flush has priority over stall. While flush=1, stall=0, idex_bubble=1, and the ID entry is discarded.
- stall_count increments on every clock where stall=1 and saturates at all-ones. It is cleared only by reset.
- Reset mid-stall: all slots are cleared asynchronously, so stall drops in the same cycle.

Decomposition:
- Shared package: the slot record typedef {valid, rd, reg_write, mem_read}, the bubble constant, SEL_W derivation, and the select encoding constant SEL_REGFILE=0.
- Sub-module hazard_slot_pipe holds the parametrised shift register of slots, with bubble insert and async reset.
- Match, priority and stall logic stay in the top.

Test Plan:
- Back-to-back dependency, FWD_STAGES=2. add $3,$1,$2 then sub $4,$3,$5 -> forward_a=1 in sub's EX cycle; stall=0.
- Distance-2 dependency. add $3 / nop / or $6,$3,$3 -> forward_a=2, forward_b=2. A competing younger write to $3 at distance 1 gives select 1.
- Load-use with LOAD_USE_DIST=1. lw $2,0($0) then add $4,$2,$2 -> stall=1 for exactly 1 cycle; idex_bubble=1; pc_write_en=0; then forward_a=2; stall_count=1.
- Load-use with LOAD_USE_DIST=2, FWD_STAGES=3. lw $7 then use $7 -> 2 consecutive stall cycles, then forward_a=3; stall_count=2.
- Register $0 and id_uses_rt=0. add $0,... then use $0 -> selects 0, no stall. lw $5 then addi with rt=$5 and id_uses_rt=0 -> no stall.
- Flush during a pending stall. flush=1 in the same cycle as a load-use match -> stall=0, idex_bubble=1, both selects 0 next cycle. Then assert reset mid-stall -> stall drops immediately and stall_count returns to 0.
